lap_timer_core: RTL

Parametrised stopwatch/countdown core, the next-generation time-keeping datapath for the stopwatch top level. It generates its own centisecond tick from `mclk` and keeps a packed BCD hh:mm:ss.cc value that counts up or down. A LAP_DEPTH-entry lap FIFO records split times. It sits between the switch interface (debounced one-cycle pulses) and the seven-segment/LED drivers, which consume `time_bcd`, `lap_data` and the status flags.

---
 rtl/lap_timer_core.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lap_timer_core.sv
// Stopwatch/countdown core: self-timed centisecond prescaler, packed BCD
// hh:mm:ss.cc counter with up/down modes, checked loads and a lap FIFO.
module lap_timer_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4,
    parameter int HOUR_MAX  = 24
) (
    input  logic                           mclk,
    input  logic                           rst,
    input  logic                           start_stop,
    input  logic                           clear,
    input  logic                           lap,
    input  logic                           lap_rd,
    input  logic                           mode_down,
    input  logic                           load,
    input  logic [27:0]                    load_time,
    output logic [27:0]                    time_bcd,
    output logic [1:0]                     state,
    output logic                           done,
    output logic                           wrap,
    output logic                           load_err,
    output logic [27:0]                    lap_data,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_full,
    output logic                           lap_ovf
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(LAP_DEPTH + 1);
    localparam int PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0]  HMAX10   = 2'((HOUR_MAX - 1) / 10);
    localparam logic [3:0]  HMAX1    = 4'((HOUR_MAX - 1) % 10);
    localparam logic [27:0] MAX_TIME = {HMAX10, HMAX1, 3'd5, 4'd9, 3'd5, 4'd9, 4'd9, 4'd9};

    logic [1:0]     state_q, state_d;
    logic [27:0]    time_q, time_d;
    logic [PSW-1:0] psc_q, psc_d;
    logic           mode_q, mode_d;
    logic           done_q, done_d;
    logic           wrap_q, wrap_d;
    logic           err_q, err_d;
    logic           tick;

    logic [27:0]    lap_mem_q [LAP_DEPTH];
    logic [PW-1:0]  rd_q, rd_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [27:0]    lapd_q, lapd_d;
    logic           full_q, full_d;
    logic           ovf_q, ovf_d;
    logic           push_req, pop_req, do_push;

    function automatic logic [27:0] bcd_inc(input logic [27:0] t);
        logic [1:0] h10;
        logic [3:0] h1, m1, s1, c10, c1;
        logic [2:0] m10, s10;
        logic       cy;
        {h10, h1, m10, m1, s10, s1, c10, c1} = t;
        cy = 1'b1;
        if (c1 == 4'd9) c1 = '0; else begin c1 = c1 + 4'd1; cy = 1'b0; end
        if (cy) begin
            if (c10 == 4'd9) c10 = '0; else begin c10 = c10 + 4'd1; cy = 1'b0; end
        end
        if (cy) begin
            if (s1 == 4'd9) s1 = '0; else begin s1 = s1 + 4'd1; cy = 1'b0; end
        end
        if (cy) begin
            if (s10 == 3'd5) s10 = '0; else begin s10 = s10 + 3'd1; cy = 1'b0; end
        end
        if (cy) begin
            if (m1 == 4'd9) m1 = '0; else begin m1 = m1 + 4'd1; cy = 1'b0; end
        end
        if (cy) begin
            if (m10 == 3'd5) m10 = '0; else begin m10 = m10 + 3'd1; cy = 1'b0; end
        end
        if (cy) begin
            if (h1 == 4'd9) begin h1 = '0; h10 = h10 + 2'd1; end
            else h1 = h1 + 4'd1;
        end
        return {h10, h1, m10, m1, s10, s1, c10, c1};
    endfunction

    // Only called with a nonzero time, so the hour borrow never underflows.
    function automatic logic [27:0] bcd_dec(input logic [27:0] t);
        logic [1:0] h10;
        logic [3:0] h1, m1, s1, c10, c1;
        logic [2:0] m10, s10;
        logic       bw;
        {h10, h1, m10, m1, s10, s1, c10, c1} = t;
        bw = 1'b1;
        if (c1 == 4'd0) c1 = 4'd9; else begin c1 = c1 - 4'd1; bw = 1'b0; end
        if (bw) begin
            if (c10 == 4'd0) c10 = 4'd9; else begin c10 = c10 - 4'd1; bw = 1'b0; end
        end
        if (bw) begin
            if (s1 == 4'd0) s1 = 4'd9; else begin s1 = s1 - 4'd1; bw = 1'b0; end
        end
        if (bw) begin
            if (s10 == 3'd0) s10 = 3'd5; else begin s10 = s10 - 3'd1; bw = 1'b0; end
        end
        if (bw) begin
            if (m1 == 4'd0) m1 = 4'd9; else begin m1 = m1 - 4'd1; bw = 1'b0; end
        end
        if (bw) begin
            if (m10 == 3'd0) m10 = 3'd5; else begin m10 = m10 - 3'd1; bw = 1'b0; end
        end
        if (bw) begin
            if (h1 == 4'd0) begin h1 = 4'd9; h10 = h10 - 2'd1; end
            else h1 = h1 - 4'd1;
        end
        return {h10, h1, m10, m1, s10, s1, c10, c1};
    endfunction

    function automatic logic bcd_legal(input logic [27:0] t);
        logic [5:0] hours;
        hours = 6'(t[27:26]) * 6'd10 + 6'(t[25:22]);
        return (t[25:22] <= 4'd9) && (t[21:19] <= 3'd5) && (t[18:15] <= 4'd9) &&
               (t[14:12] <= 3'd5) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd9) &&
               (t[3:0] <= 4'd9) && (hours < 6'(HOUR_MAX));
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LAP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign tick = (state_q == S_RUN) && (psc_q == PSW'(DIV - 1));

    // Pause freezes the prescaler so a resume continues the partial tick.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        psc_d   = psc_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            time_d  = '0;
            psc_d   = '0;
        end else begin
            if (state_q == S_RUN) psc_d = tick ? '0 : psc_q + PSW'(1);
            case (state_q)
                S_IDLE: begin
                    if (start_stop && !(mode_down && time_q == '0)) begin
                        state_d = S_RUN;
                        mode_d  = mode_down;
                        psc_d   = '0;
                    end
                end
                S_RUN: begin
                    if (start_stop) state_d = S_PAUSE;
                    if (tick) begin
                        if (mode_q) begin
                            if (time_q <= 28'd1) begin
                                time_d  = '0;
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end else begin
                                time_d = bcd_dec(time_q);
                            end
                        end else if (time_q == MAX_TIME) begin
                            time_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            time_d = bcd_inc(time_q);
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_stop) state_d = S_RUN;
                end
                default: begin
                end
            endcase
            if (load) begin
                if ((state_q == S_IDLE || state_q == S_PAUSE) && bcd_legal(load_time))
                    time_d = load_time;
                else
                    err_d = 1'b1;
            end
        end
    end

    assign push_req = lap && (state_q == S_RUN) && !clear;
    assign pop_req  = lap_rd && (cnt_q != '0) && !clear;
    assign do_push  = push_req && (!full_q || pop_req);

    // The head register is computed ahead so lap_data stays a pure flop output.
    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        lapd_d = lapd_q;
        if (clear) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (push_req && !do_push) ovf_d = 1'b1;
            if (do_push) wr_d = ptr_inc(wr_q);
            if (pop_req) rd_d = ptr_inc(rd_q);
            if (do_push && !pop_req)      cnt_d = cnt_q + CW'(1);
            else if (pop_req && !do_push) cnt_d = cnt_q - CW'(1);
        end
        if (cnt_d == '0)       lapd_d = '0;
        else if (pop_req)      lapd_d = (cnt_q > CW'(1)) ? lap_mem_q[ptr_inc(rd_q)] : time_q;
        else if (cnt_q == '0)  lapd_d = time_q;
        full_d = (cnt_d == CW'(LAP_DEPTH));
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            time_q  <= '0;
            psc_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            lapd_q  <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            psc_q   <= psc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            lapd_q  <= lapd_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge mclk) begin
        if (do_push) lap_mem_q[wr_q] <= time_q;
    end

    assign time_bcd  = time_q;
    assign state     = state_q;
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign load_err  = err_q;
    assign lap_data  = lapd_q;
    assign lap_count = cnt_q;
    assign lap_full  = full_q;
    assign lap_ovf   = ovf_q;

endmodule
